// File: rtl/noc_pkg.sv
// Shared NoC types for the VC input buffer: flit layout, label encoding, VC sizing.
// Ordering checker in noc_vc_input_buffer is enabled by defining NOC_VC_BUF_CHECK_EN.
package noc_pkg;

  localparam int unsigned VC_NUM      = 4;
  // Keep vc_id at least one bit wide so a single-VC build still has a field.
  localparam int unsigned VC_SIZE     = ($clog2(VC_NUM) > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned FLIT_DATA_W = 16;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t              label;
    logic [VC_SIZE-1:0]       vc_id;
    logic [FLIT_DATA_W-1:0]   data;
  } flit_t;

  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_PKT  = 1'b1
  } vc_state_t;

endpackage

// File: rtl/noc_vc_input_buffer_if.sv
// Write/read/credit bundle between the upstream link, the switch allocator and the VC input buffer.
interface noc_vc_input_buffer_if #(
  parameter int unsigned VC_NUM = noc_pkg::VC_NUM
) ();
  import noc_pkg::*;

  logic                 in_valid;
  flit_t                in_flit;
  logic                 rd_en;
  logic [VC_SIZE-1:0]   rd_vc;
  flit_t                rd_flit;
  logic [VC_NUM-1:0]    vc_nonempty;
  logic [VC_NUM-1:0]    vc_pkt_active;
  logic                 credit_valid;
  logic [VC_SIZE-1:0]   credit_vc;
  logic                 overflow;
  logic                 proto_err;

  modport master (
    output in_valid, in_flit, rd_en, rd_vc,
    input  rd_flit, vc_nonempty, vc_pkt_active, credit_valid, credit_vc, overflow, proto_err
  );

  modport slave (
    input  in_valid, in_flit, rd_en, rd_vc,
    output rd_flit, vc_nonempty, vc_pkt_active, credit_valid, credit_vc, overflow, proto_err
  );

endinterface

// File: rtl/noc_fifo.sv
// Single circular flit FIFO with combinational head peek; a push into a full FIFO is
// accepted only when the same cycle also pops.
module noc_fifo import noc_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  flit_t wdata,
  output flit_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  flit_t             mem [DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Per-VC input buffer: VC_NUM FIFOs, packet-framing FSM per VC, credit return, sticky errors.
// Define NOC_VC_BUF_CHECK_EN to build the flit-ordering checker driving proto_err.
module noc_vc_input_buffer #(
  parameter int unsigned VC_NUM = noc_pkg::VC_NUM,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_vc_input_buffer_if.slave  bus
);
  import noc_pkg::*;

  logic [VC_NUM-1:0]  hit;
  logic [VC_NUM-1:0]  push;
  logic [VC_NUM-1:0]  pop;
  logic [VC_NUM-1:0]  full;
  logic [VC_NUM-1:0]  empty;
  flit_t              rdata [VC_NUM];
  flit_label_t        label;
  logic               credit_valid;
  logic [VC_SIZE-1:0] credit_vc;
  logic               overflow;

  assign label = bus.in_flit.label;

`ifdef NOC_VC_BUF_CHECK_EN
  logic [VC_NUM-1:0]  order_err;
  logic               proto_err;
`endif

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    vc_state_t state;

    assign hit[g]  = bus.in_valid && (bus.in_flit.vc_id == VC_SIZE'(g));
    assign pop[g]  = bus.rd_en && (bus.rd_vc == VC_SIZE'(g)) && !empty[g];
    assign push[g] = hit[g] && (!full[g] || pop[g]);

    noc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (bus.in_flit),
      .rdata (rdata[g]),
      .full  (full[g]),
      .empty (empty[g])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= VC_IDLE;
      end else if (push[g]) begin
`ifdef NOC_VC_BUF_CHECK_EN
        // Resynchronise on errors: the label alone says whether a packet is now open.
        state <= (label == FLIT_HEAD || label == FLIT_BODY) ? VC_PKT : VC_IDLE;
`else
        case (label)
          FLIT_HEAD: state <= VC_PKT;
          FLIT_TAIL: state <= VC_IDLE;
          default:   state <= state;
        endcase
`endif
      end
    end

`ifdef NOC_VC_BUF_CHECK_EN
    assign order_err[g] = push[g] && ((state == VC_IDLE)
                          ? (label == FLIT_BODY || label == FLIT_TAIL)
                          : (label == FLIT_HEAD || label == FLIT_HEADTAIL));
`endif

    assign bus.vc_nonempty[g]   = !empty[g];
    assign bus.vc_pkt_active[g] = (state == VC_PKT);
  end

  always_comb begin
    bus.rd_flit = '0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      if (bus.rd_vc == VC_SIZE'(i)) bus.rd_flit = rdata[i];
    end
  end

  // Any valid flit not pushed anywhere was dropped: full VC or out-of-range vc_id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      overflow     <= 1'b0;
    end else begin
      credit_valid <= |pop;
      if (|pop) credit_vc <= bus.rd_vc;
      if (bus.in_valid && !(|push)) overflow <= 1'b1;
    end
  end

`ifdef NOC_VC_BUF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err <= 1'b0;
    else if (|order_err) proto_err <= 1'b1;
  end
  assign bus.proto_err = proto_err;
`else
  assign bus.proto_err = 1'b0;
`endif

  assign bus.credit_valid = credit_valid;
  assign bus.credit_vc    = credit_vc;
  assign bus.overflow     = overflow;

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Bench for noc_vc_input_buffer (VC_NUM=4, DEPTH=4): vector table, directed corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_noc_vc_input_buffer;
  import noc_pkg::*;

  localparam int unsigned NVC = 4;
  localparam int unsigned DEP = 4;
  localparam bit CHECK =
`ifdef NOC_VC_BUF_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_vc_input_buffer_if #(.VC_NUM(NVC)) bus ();

  noc_vc_input_buffer #(.VC_NUM(NVC), .DEPTH(DEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one queue per VC plus the observable flags.
  flit_t              mq [NVC][$];
  bit                 m_open [NVC];
  bit                 m_ovf, m_perr, m_cr;
  logic [VC_SIZE-1:0] m_crvc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NVC; v++) begin
      mq[v].delete();
      m_open[v] = 1'b0;
    end
    m_ovf = 1'b0; m_perr = 1'b0; m_cr = 1'b0; m_crvc = '0;
  endtask

  task automatic check_all();
    logic [NVC-1:0] ne, act;
    flit_t head;
    for (int v = 0; v < NVC; v++) begin
      ne[v]  = (mq[v].size() != 0);
      act[v] = m_open[v];
    end
    head = (mq[bus.rd_vc].size() != 0) ? mq[bus.rd_vc][0] : '0;
    chk("vc_nonempty", bus.vc_nonempty, ne);
    chk("vc_pkt_active", bus.vc_pkt_active, act);
    chk("credit_valid", bus.credit_valid, m_cr);
    if (m_cr) chk("credit_vc", bus.credit_vc, m_crvc);
    chk("overflow", bus.overflow, m_ovf);
    chk("proto_err", bus.proto_err, m_perr);
    chk("rd_flit", bus.rd_flit, head);
  endtask

  // Apply one cycle of stimulus, advance the model by the buffer's rules, then compare.
  task automatic step(input bit wv, input flit_t f, input bit re, input logic [VC_SIZE-1:0] rv);
    int  wvc;
    bit  popd, acc, opened;
    bus.in_valid = wv; bus.in_flit = f; bus.rd_en = re; bus.rd_vc = rv;
    @(posedge clk);
    wvc  = int'(f.vc_id);
    popd = re && (mq[rv].size() != 0);
    acc  = wv && (wvc < NVC) && ((mq[wvc].size() < DEP) || (popd && int'(rv) == wvc));
    if (popd) void'(mq[rv].pop_front());
    if (acc) begin
      opened = m_open[wvc];
      if (CHECK) begin
        if (opened == (f.label == FLIT_BODY || f.label == FLIT_TAIL) ? 1'b0 : 1'b1) m_perr = 1'b1;
        m_open[wvc] = (f.label == FLIT_HEAD || f.label == FLIT_BODY);
      end else begin
        if (f.label == FLIT_HEAD) m_open[wvc] = 1'b1;
        if (f.label == FLIT_TAIL) m_open[wvc] = 1'b0;
      end
      mq[wvc].push_back(f);
    end else if (wv) begin
      m_ovf = 1'b1;
    end
    m_cr = popd;
    if (popd) m_crvc = rv;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_flit = '0; bus.rd_en = 1'b0; bus.rd_vc = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  function automatic flit_t mk(input logic [1:0] vc, input flit_label_t l, input logic [15:0] d);
    flit_t f;
    f.label = l; f.vc_id = vc; f.data = d;
    return f;
  endfunction

  typedef struct {
    bit          wv;
    logic [1:0]  vc;
    flit_label_t lbl;
    logic [15:0] data;
    bit          re;
    logic [1:0]  rv;
    logic [3:0]  e_ne;
    logic [3:0]  e_act;
    bit          e_cr;
    logic [15:0] e_rdd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // One packet through VC2, drained by four pops, then a pop on the now-empty VC2.
    tbl[0] = '{1, 2, FLIT_HEAD, 16'hA1, 0, 2, 4'b0100, 4'b0100, 0, 16'hA1};
    tbl[1] = '{1, 2, FLIT_BODY, 16'hA2, 0, 2, 4'b0100, 4'b0100, 0, 16'hA1};
    tbl[2] = '{1, 2, FLIT_BODY, 16'hA3, 0, 2, 4'b0100, 4'b0100, 0, 16'hA1};
    tbl[3] = '{1, 2, FLIT_TAIL, 16'hA4, 0, 2, 4'b0100, 4'b0000, 0, 16'hA1};
    tbl[4] = '{0, 0, FLIT_HEAD, 16'h00, 1, 2, 4'b0100, 4'b0000, 1, 16'hA2};
    tbl[5] = '{0, 0, FLIT_HEAD, 16'h00, 1, 2, 4'b0100, 4'b0000, 1, 16'hA3};
    tbl[6] = '{0, 0, FLIT_HEAD, 16'h00, 1, 2, 4'b0100, 4'b0000, 1, 16'hA4};
    tbl[7] = '{0, 0, FLIT_HEAD, 16'h00, 1, 2, 4'b0000, 4'b0000, 1, 16'h00};
    tbl[8] = '{0, 0, FLIT_HEAD, 16'h00, 1, 2, 4'b0000, 4'b0000, 0, 16'h00};
    tbl[9] = '{0, 0, FLIT_HEAD, 16'h00, 0, 2, 4'b0000, 4'b0000, 0, 16'h00};

    do_reset();
    chk("reset_nonempty", bus.vc_nonempty, 4'b0000);
    chk("reset_credit", bus.credit_valid, 1'b0);
    chk("reset_overflow", bus.overflow, 1'b0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wv, mk(tbl[i].vc, tbl[i].lbl, tbl[i].data), tbl[i].re, tbl[i].rv);
      chk($sformatf("tbl%0d_nonempty", i), bus.vc_nonempty, tbl[i].e_ne);
      chk($sformatf("tbl%0d_active", i), bus.vc_pkt_active, tbl[i].e_act);
      chk($sformatf("tbl%0d_credit", i), bus.credit_valid, tbl[i].e_cr);
      if (tbl[i].e_cr) chk($sformatf("tbl%0d_credit_vc", i), bus.credit_vc, 2'd2);
      chk($sformatf("tbl%0d_rd_data", i), bus.rd_flit.data, tbl[i].e_rdd);
    end
    chk("empty_vc_rd_flit_zero", bus.rd_flit, '0);

    // Full VC1: drop without pop, accept with same-cycle pop.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, mk(1, (i == 0) ? FLIT_HEAD : FLIT_BODY, 16'h100 + 16'(i)), 0, 1);
    chk("pre_full_overflow", bus.overflow, 1'b0);
    step(1, mk(1, FLIT_BODY, 16'h1FF), 0, 1);
    chk("full_drop_overflow", bus.overflow, 1'b1);
    chk("full_drop_head", bus.rd_flit.data, 16'h100);
    step(1, mk(1, FLIT_BODY, 16'h104), 1, 1);
    chk("full_pop_push_head", bus.rd_flit.data, 16'h101);
    chk("full_pop_push_overflow", bus.overflow, 1'b1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 1);
    chk("full_drained", bus.vc_nonempty, 4'b0000);

    // Interleaved VC0/VC3 writes with continuous VC3 pops; VC3 pointers wrap.
    do_reset();
    for (int i = 0; i < 12; i++)
      step(1, mk((i % 3 == 0) ? 2'd0 : 2'd3, FLIT_HEADTAIL, 16'h300 + 16'(i)), 1, 3);
    for (int i = 0; i < 6; i++) step(0, '0, 1, (i < 2) ? 2'd3 : 2'd0);
    chk("interleave_no_loss", bus.overflow, 1'b0);
    chk("interleave_drained", bus.vc_nonempty, 4'b0000);

    // BODY into an idle VC.
    do_reset();
    step(1, mk(0, FLIT_BODY, 16'h0B0D), 0, 0);
    chk("body_idle_proto_err", bus.proto_err, CHECK);
    chk("body_idle_active", bus.vc_pkt_active[0], CHECK);

    // Asynchronous reset mid-packet with a credit pending.
    do_reset();
    step(1, mk(1, FLIT_HEAD, 16'h0EAD), 0, 1);
    step(1, mk(1, FLIT_BODY, 16'h0B0D), 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_nonempty", bus.vc_nonempty, 4'b0000);
    chk("async_rst_active", bus.vc_pkt_active, 4'b0000);
    chk("async_rst_credit", bus.credit_valid, 1'b0);
    model_clear();
    bus.in_valid = 1'b0; bus.rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, mk(1, FLIT_HEADTAIL, 16'h0C0C), 0, 1);
    chk("post_rst_headtail", bus.rd_flit.data, 16'h0C0C);
    chk("post_rst_proto_err", bus.proto_err, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 60,
           mk(2'($urandom_range(0, 3)), flit_label_t'($urandom_range(0, 3)), 16'($urandom)),
           $urandom_range(0, 99) < 50,
           2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_vc_input_buffer.md
NOC_VC_INPUT_BUFFER -- requirements
Module: noc_vc_input_buffer

Interface
REQ-001 SHALL have parameter VC_NUM, default noc_pkg::VC_NUM, number of virtual channels (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, flits per VC FIFO (>=2, any integer).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_flit is valid this cycle.
REQ-006 SHALL have port in_flit  input  flit_t  incoming flit; vc_id selects target FIFO.
REQ-007 SHALL have port rd_en  input  1  pop request from switch allocator.
REQ-008 SHALL have port rd_vc  input  VC_SIZE  VC to pop or peek.
REQ-009 SHALL have port rd_flit  output  flit_t  head flit of FIFO rd_vc (combinational peek).
REQ-010 SHALL have port vc_nonempty  output  VC_NUM  bit i set when FIFO i holds >=1 flit.
REQ-011 SHALL have port vc_pkt_active  output  VC_NUM  bit i set while VC i is mid-packet on input side.
REQ-012 SHALL have port credit_valid  output  1  one credit returned upstream.
REQ-013 SHALL have port credit_vc  output  VC_SIZE  VC of returned credit.
REQ-014 SHALL have port overflow  output  1  sticky; write attempted to full VC.
REQ-015 SHALL have port proto_err  output  1  sticky flit-ordering error (see Configuration).

Function
REQ-016 SHALL write in_flit into FIFO in_flit.vc_id when in_valid=1 and that FIFO is not full, or is full but popped the same cycle.
REQ-017 SHALL drop a flit written to a full FIFO with no same-cycle pop, leaving contents unchanged, and set overflow.
REQ-018 SHALL pop FIFO rd_vc when rd_en=1 and it is nonempty; rd_en on an empty VC is a no-op with no credit.
REQ-019 SHALL make a written flit visible on vc_nonempty/rd_flit the cycle after the write (no bypass).
REQ-020 SHALL assert credit_valid with credit_vc=rd_vc exactly one cycle after each successful pop, for one cycle.
REQ-021 SHALL allow simultaneous write and pop on the same or different VCs in one cycle; occupancy of the same VC then unchanged.
REQ-022 SHALL wrap read/write pointers from DEPTH-1 to 0; occupancy counter width $clog2(DEPTH+1).
REQ-023 SHALL drive rd_flit to zero when FIFO rd_vc is empty.
REQ-024 SHALL run per-VC FSM on accepted writes: IDLE --HEAD--> PKT; PKT --TAIL--> IDLE; HEADTAIL keeps IDLE; BODY keeps PKT; vc_pkt_active=1 in PKT.
REQ-025 SHALL ignore vc_id values >= VC_NUM (flit dropped, overflow set).

Reset
REQ-026 SHALL on rst_n=0 asynchronously clear all pointers, counters, FSMs to IDLE, credit_valid, overflow, proto_err; FIFO storage need not be cleared.
REQ-027 SHALL discard all buffered flits and pending credits if reset asserts mid-packet.

Configuration
REQ-028 SHALL compile the ordering checker only when NOC_VC_BUF_CHECK_EN is defined: BODY/TAIL accepted in IDLE, or HEAD/HEADTAIL accepted in PKT, sets proto_err; flit is still stored and FSM follows REQ-024 (HEAD forces PKT, TAIL forces IDLE).
REQ-029 SHALL without NOC_VC_BUF_CHECK_EN tie proto_err to 0 and contain no checker logic.

Structure
REQ-030 SHALL take flit_t, flit_label_t, VC_NUM, VC_SIZE from noc_pkg; VC_SIZE SHALL be redefined there as max(1,$clog2(VC_NUM)) so VC_NUM=1 keeps a 1-bit vc_id.
REQ-031 SHALL instantiate VC_NUM copies of sub-module noc_fifo (single circular FIFO, parameter DEPTH, push/pop/peek/full/empty).

Verification (VC_NUM=4, DEPTH=4)
REQ-032 SHALL cover: 4 flits HEAD,BODY,BODY,TAIL to VC2, then 4 pops -> vc_nonempty[2] cycle after first write, flits out in order, 4 credits vc=2 each one cycle after pop.
REQ-033 SHALL cover: 5th write to full VC1 with no pop -> flit dropped, overflow=1, count stays 4; repeat with same-cycle pop -> accepted, count 4, overflow unchanged.
REQ-034 SHALL cover: interleaved writes VC0/VC3 with concurrent pops of VC3 -> independent ordering per VC, pointers wrap after 4+ flits, no loss.
REQ-035 SHALL cover: BODY to idle VC0 -> proto_err=1 with NOC_VC_BUF_CHECK_EN, 0 without; vc_pkt_active[0]=1 with, unchanged 0 without.
REQ-036 SHALL cover: rst_n low after HEAD+BODY on VC1 -> vc_nonempty=0, vc_pkt_active=0, credit_valid=0 immediately (asynchronously); next HEADTAIL accepted cleanly.
REQ-037 SHALL cover: rd_en on empty VC2 -> no pop, no credit, rd_flit=0.
